// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID verification controller.
package sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1403181268;

  function automatic logic state_is_busy(state_e s);
    return !(s inside {S_IDLE, S_PASS, S_FAIL});
  endfunction

endpackage

// File: rtl/sysid_verify_ctrl_avm_single_read.sv
// Single Avalon-MM read engine: drives the read strobe, counts stall cycles
// against the timeout limit and times the readdata latency window.
module avm_single_read #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        lat_wait,
  input  logic        addr,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        accept,
  output logic        data_valid,
  output logic        timed_out,
  output logic [31:0] rdata
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] LAT_LOAD  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;

  always_comb begin
    timed_out  = rd_req && (tmo_cnt_q == TMO_LIMIT);
    // The strobe is withheld for the timeout cycle so the slave sees a fresh request on retry.
    m_read     = rd_req && !timed_out;
    m_address  = addr;
    accept     = m_read && !m_waitrequest;
    data_valid = (READ_LATENCY == 0) ? accept : (lat_wait && (lat_cnt_q == 2'd0));
    rdata      = m_readdata;

    tmo_cnt_d = tmo_cnt_q;
    if (accept || timed_out) begin
      tmo_cnt_d = 8'd0;
    end else if (m_read && m_waitrequest) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    lat_cnt_d = lat_cnt_q;
    if (accept) begin
      lat_cnt_d = LAT_LOAD;
    end else if (lat_wait && (lat_cnt_q != 2'd0)) begin
      lat_cnt_d = lat_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= 8'd0;
      lat_cnt_q <= 2'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/sysid_verify_ctrl.sv
// Boot-time system-ID check: reads ID and timestamp words, compares them with
// build-time values and gates downstream logic until the image is verified.
//   state    | meaning
//   S_IDLE   | waiting for auto-start or start
//   S_RD_ID  | read strobe on word 0
//   S_LAT_ID | waiting for word 0 readdata
//   S_RD_TS  | read strobe on word 1
//   S_LAT_TS | waiting for word 1 readdata
//   S_CHECK  | compare captured words
//   S_PASS   | verified, system_enable high
//   S_FAIL   | mismatch or timeout
module sysid_verify_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        system_enable
);

  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [1:0]  retry_cnt_q, retry_cnt_d;
  logic [31:0] read_id_q, read_id_d, read_ts_q, read_ts_d;
  logic        done_q, done_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d, system_enable_q, system_enable_d;

  logic        rd_req, lat_wait, rd_addr, begin_run;
  logic        accept, data_valid, timed_out;
  logic [31:0] rdata;

  avm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clock        (clock),
    .reset        (reset),
    .rd_req       (rd_req),
    .lat_wait     (lat_wait),
    .addr         (rd_addr),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_waitrequest(m_waitrequest),
    .m_readdata   (m_readdata),
    .accept       (accept),
    .data_valid   (data_valid),
    .timed_out    (timed_out),
    .rdata        (rdata)
  );

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    retry_cnt_d     = retry_cnt_q;
    read_id_d       = read_id_q;
    read_ts_d       = read_ts_q;
    done_d          = done_q;
    id_ok_d         = id_ok_q;
    ts_ok_d         = ts_ok_q;
    timeout_d       = timeout_q;
    system_enable_d = system_enable_q;
    rd_req          = 1'b0;
    lat_wait        = 1'b0;
    rd_addr         = SYSID_ADDR_ID;
    begin_run       = 1'b0;

    unique case (state_q)
      S_IDLE: begin_run = pending_q || start;
      S_PASS, S_FAIL: begin_run = start;
      S_RD_ID: begin
        rd_req = 1'b1;
        if (data_valid) begin
          read_id_d = rdata;
          state_d   = S_RD_TS;
        end else if (accept) begin
          state_d = S_LAT_ID;
        end
      end
      S_LAT_ID: begin
        lat_wait = 1'b1;
        if (data_valid) begin
          read_id_d = rdata;
          state_d   = S_RD_TS;
        end
      end
      S_RD_TS: begin
        rd_req  = 1'b1;
        rd_addr = SYSID_ADDR_TS;
        if (data_valid) begin
          read_ts_d = rdata;
          state_d   = S_CHECK;
        end else if (accept) begin
          state_d = S_LAT_TS;
        end
      end
      S_LAT_TS: begin
        lat_wait = 1'b1;
        rd_addr  = SYSID_ADDR_TS;
        if (data_valid) begin
          read_ts_d = rdata;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        id_ok_d         = (read_id_q == EXPECTED_ID);
        ts_ok_d         = (read_ts_q == EXPECTED_TS);
        system_enable_d = id_ok_d && ts_ok_d;
        done_d          = 1'b1;
        state_d         = system_enable_d ? S_PASS : S_FAIL;
      end
    endcase

    // A stalled read restarts the whole sequence so both words come from one attempt.
    if (timed_out) begin
      if (retry_cnt_q < RETRY_LIMIT) begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        state_d     = S_RD_ID;
      end else begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
        state_d   = S_FAIL;
      end
    end

    if (begin_run) begin
      state_d         = S_RD_ID;
      pending_d       = 1'b0;
      retry_cnt_d     = 2'd0;
      done_d          = 1'b0;
      id_ok_d         = 1'b0;
      ts_ok_d         = 1'b0;
      timeout_d       = 1'b0;
      system_enable_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pending_q       <= (AUTO_START != 0);
      retry_cnt_q     <= 2'd0;
      read_id_q       <= 32'd0;
      read_ts_q       <= 32'd0;
      done_q          <= 1'b0;
      id_ok_q         <= 1'b0;
      ts_ok_q         <= 1'b0;
      timeout_q       <= 1'b0;
      system_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      retry_cnt_q     <= retry_cnt_d;
      read_id_q       <= read_id_d;
      read_ts_q       <= read_ts_d;
      done_q          <= done_d;
      id_ok_q         <= id_ok_d;
      ts_ok_q         <= ts_ok_d;
      timeout_q       <= timeout_d;
      system_enable_q <= system_enable_d;
    end
  end

  assign busy          = state_is_busy(state_q);
  assign read_id       = read_id_q;
  assign read_ts       = read_ts_q;
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign timeout       = timeout_q;
  assign system_enable = system_enable_q;

endmodule
